// File: rtl/fetch_unit.sv
// Instruction fetch stage: owns the PC, reads a combinational imem, registers IF/ID (1 edge; 2 edges + bubble for two-word).
// Stall freezes PC, state, hold word and IF/ID; pc_write overrides stall and flushes IF/ID.
module fetch_unit #(
   parameter int                      PC_WIDTH     = 32,
   parameter int                      INSTR_WIDTH  = 16,
   parameter logic [PC_WIDTH-1:0]     RESET_VECTOR = 32,
   parameter logic [INSTR_WIDTH-1:0]  NOP_WORD     = '0,
   parameter int                      IMM_FLAG_BIT = 15
) (
   input  logic                   clk,
   input  logic                   reset,
   input  logic                   stall,
   input  logic                   pc_write,
   input  logic [PC_WIDTH-1:0]    pc_write_back_value,
   input  logic                   clear_instruction,
   output logic [PC_WIDTH-1:0]    imem_addr,
   input  logic [INSTR_WIDTH-1:0] imem_rdata,
   output logic [INSTR_WIDTH-1:0] instruction_r,
   output logic [INSTR_WIDTH-1:0] immediate_r,
   output logic [PC_WIDTH-1:0]    pc_plus_one_r,
   output logic                   valid_r
);

   localparam logic S_FETCH = 1'b0;
   localparam logic S_IMM   = 1'b1;

   logic                   r_state;
   logic [PC_WIDTH-1:0]    r_pc;
   logic [INSTR_WIDTH-1:0] r_hold;
   logic [INSTR_WIDTH-1:0] r_instr;
   logic [INSTR_WIDTH-1:0] r_imm;
   logic [PC_WIDTH-1:0]    r_pc_plus_one;
   logic                   r_valid;

   logic [PC_WIDTH-1:0]    w_pc_inc;
   logic                   w_has_imm;

   // Natural wrap: all-ones + 1 gives 0.
   assign w_pc_inc  = r_pc + {{(PC_WIDTH-1){1'b0}}, 1'b1};
   assign w_has_imm = imem_rdata[IMM_FLAG_BIT];

   always_ff @(posedge clk) begin
      if (reset) begin
         r_pc          <= RESET_VECTOR;
         r_state       <= S_FETCH;
         r_hold        <= NOP_WORD;
         r_instr       <= NOP_WORD;
         r_imm         <= '0;
         r_pc_plus_one <= '0;
         r_valid       <= 1'b0;
      end else if (pc_write) begin
         r_pc    <= pc_write_back_value;
         r_state <= S_FETCH;
         r_hold  <= NOP_WORD;
         r_instr <= NOP_WORD;
         r_valid <= 1'b0;
      end else if (stall) begin
         r_pc <= r_pc;
      end else if (clear_instruction) begin
         // PC is left alone so the same word is fetched again next cycle.
         r_instr <= NOP_WORD;
         r_valid <= 1'b0;
      end else if (r_state == S_FETCH) begin
         r_pc <= w_pc_inc;
         if (w_has_imm) begin
            r_hold  <= imem_rdata;
            r_instr <= NOP_WORD;
            r_valid <= 1'b0;
            r_state <= S_IMM;
         end else begin
            r_instr       <= imem_rdata;
            r_imm         <= '0;
            r_pc_plus_one <= w_pc_inc;
            r_valid       <= 1'b1;
         end
      end else begin
         r_pc          <= w_pc_inc;
         r_instr       <= r_hold;
         r_imm         <= imem_rdata;
         r_pc_plus_one <= w_pc_inc;
         r_valid       <= 1'b1;
         r_state       <= S_FETCH;
      end
   end

   assign imem_addr     = r_pc;
   assign instruction_r = r_instr;
   assign immediate_r   = r_imm;
   assign pc_plus_one_r = r_pc_plus_one;
   assign valid_r       = r_valid;

endmodule

// File: tb/tb_fetch_unit.sv
// Scoreboarded bench for fetch_unit: a program-order reference model predicts IF/ID contents after every edge.
module tb_fetch_unit;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        stall = 1'b0;
   logic        pc_write = 1'b0;
   logic [31:0] pc_write_back_value = '0;
   logic        clear_instruction = 1'b0;
   logic [31:0] imem_addr;
   logic [15:0] imem_rdata;
   logic [15:0] instruction_r;
   logic [15:0] immediate_r;
   logic [31:0] pc_plus_one_r;
   logic        valid_r;

   fetch_unit dut (
      .clk                 (clk),
      .reset               (reset),
      .stall               (stall),
      .pc_write            (pc_write),
      .pc_write_back_value (pc_write_back_value),
      .clear_instruction   (clear_instruction),
      .imem_addr           (imem_addr),
      .imem_rdata          (imem_rdata),
      .instruction_r       (instruction_r),
      .immediate_r         (immediate_r),
      .pc_plus_one_r       (pc_plus_one_r),
      .valid_r             (valid_r)
   );

   always #5 clk = ~clk;

   // Fixed program image; unlisted addresses get a hashed word (about 1 in 4 is two-word).
   function automatic logic [15:0] mem(input logic [31:0] a);
      logic [31:0] h;
      case (a)
         32'd32:        return 16'h0001;
         32'd33:        return 16'h0002;
         32'd34:        return 16'h0003;
         32'd40:        return 16'h0140;
         32'd41:        return 16'h0141;
         32'd50:        return 16'h0150;
         32'd51:        return 16'h0151;
         32'h60:        return 16'h8005;
         32'h61:        return 16'h1234;
         32'h100:       return 16'h0A00;
         32'hFFFF_FFFF: return 16'h0777;
         32'h0:         return 16'h0123;
         default: begin
            h = a * 32'h9E37_79B1;
            return {h[31] & h[30], h[29:15]};
         end
      endcase
   endfunction

   always_comb imem_rdata = mem(imem_addr);

   typedef struct {
      logic [31:0] addr;
      logic [15:0] instr;
      logic [15:0] imm;
      logic [31:0] ppo;
      logic        valid;
   } exp_t;

   exp_t sb[$];
   int   n_checks = 0;
   int   n_pass   = 0;

   // Reference model: program counter plus a queue of first words awaiting their immediate.
   logic [31:0] m_pc = 32'd32;
   logic [15:0] m_pending[$];
   exp_t        m_out = '{addr: 32'd32, instr: 16'h0, imm: 16'h0, ppo: 32'h0, valid: 1'b0};

   task automatic model_edge(input logic rst, input logic pcw, input logic [31:0] tgt,
                             input logic stl, input logic clr);
      logic [15:0] w;
      w = mem(m_pc);
      if (rst) begin
         m_pc = 32'd32;
         m_pending.delete();
         m_out.instr = 16'h0; m_out.imm = 16'h0; m_out.ppo = 32'h0; m_out.valid = 1'b0;
      end else if (pcw) begin
         m_pc = tgt;
         m_pending.delete();
         m_out.instr = 16'h0; m_out.valid = 1'b0;
      end else if (stl) begin
         m_pc = m_pc;
      end else if (clr) begin
         m_out.instr = 16'h0; m_out.valid = 1'b0;
      end else if (m_pending.size() != 0) begin
         m_out.instr = m_pending.pop_front();
         m_out.imm   = w;
         m_out.ppo   = m_pc + 32'd1;
         m_out.valid = 1'b1;
         m_pc        = m_pc + 32'd1;
      end else if (w[15]) begin
         m_pending.push_back(w);
         m_out.instr = 16'h0; m_out.valid = 1'b0;
         m_pc        = m_pc + 32'd1;
      end else begin
         m_out.instr = w;
         m_out.imm   = 16'h0;
         m_out.ppo   = m_pc + 32'd1;
         m_out.valid = 1'b1;
         m_pc        = m_pc + 32'd1;
      end
      m_out.addr = m_pc;
   endtask

   // Called #1 after an edge: drive inputs, predict, wait for the edge, then post the prediction.
   task automatic step(input logic rst, input logic pcw, input logic [31:0] tgt,
                       input logic stl, input logic clr);
      reset = rst; pc_write = pcw; pc_write_back_value = tgt;
      stall = stl; clear_instruction = clr;
      if (!rst && imem_addr !== m_pc) begin
         n_checks++;
         $display("FAIL pre_edge_addr got %h expected %h", imem_addr, m_pc);
      end
      model_edge(rst, pcw, tgt, stl, clr);
      @(posedge clk);
      sb.push_back(m_out);
      #1;
   endtask

   task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got === exp) n_pass++;
      else $display("FAIL %s got %h expected %h", name, got, exp);
   endtask

   always @(negedge clk) begin
      exp_t e;
      if (sb.size() != 0) begin
         e = sb.pop_front();
         check("imem_addr",     imem_addr,                 e.addr);
         check("instruction_r", {16'h0, instruction_r},    {16'h0, e.instr});
         check("immediate_r",   {16'h0, immediate_r},      {16'h0, e.imm});
         check("pc_plus_one_r", pc_plus_one_r,             e.ppo);
         check("valid_r",       {31'h0, valid_r},          {31'h0, e.valid});
      end
   end

   initial begin
      logic [31:0] tgt;
      int          sel;
      #1;
      // Reset and straight-line single-word code at the reset vector
      step(1, 0, 0, 0, 0);
      step(1, 0, 0, 0, 0);
      repeat (3) step(0, 0, 0, 0, 0);
      // Two-word instruction: bubble, then instruction with immediate
      step(0, 1, 32'h60, 0, 0);
      repeat (3) step(0, 0, 0, 0, 0);
      // Stall three cycles at PC 40, then resume
      step(0, 1, 32'd40, 0, 0);
      repeat (3) step(0, 0, 0, 1, 0);
      repeat (3) step(0, 0, 0, 0, 0);
      // Redirect plus stall while an immediate is pending
      step(0, 1, 32'h60, 0, 0);
      step(0, 0, 0, 0, 0);
      step(0, 1, 32'h100, 1, 0);
      repeat (2) step(0, 0, 0, 0, 0);
      // Bubble insertion at PC 50
      step(0, 1, 32'd50, 0, 0);
      step(0, 0, 0, 0, 1);
      repeat (2) step(0, 0, 0, 0, 0);
      // PC wrap at all-ones
      step(0, 1, 32'hFFFF_FFFF, 0, 0);
      repeat (2) step(0, 0, 0, 0, 0);
      // Reset while an immediate is pending
      step(0, 1, 32'h60, 0, 0);
      step(0, 0, 0, 0, 0);
      step(1, 0, 0, 0, 0);
      repeat (2) step(0, 0, 0, 0, 0);
      // Random mix of all controls, including simultaneous ones
      for (int i = 0; i < 600; i++) begin
         sel = $urandom_range(0, 3);
         tgt = (sel == 0) ? 32'hFFFF_FFFF : (sel == 1) ? 32'h60 : $urandom;
         step(($urandom_range(0, 63) == 0), ($urandom_range(0, 9) == 0), tgt,
              ($urandom_range(0, 4) == 0), ($urandom_range(0, 7) == 0));
      end
      step(0, 0, 0, 0, 0);
      for (int i = 0; i < 10 && sb.size() != 0; i++) @(posedge clk);
      if (sb.size() != 0) begin
         n_checks++;
         $display("FAIL scoreboard_drain got %0d expected 0", sb.size());
      end
      @(posedge clk);
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule

// File: doc/fetch_unit.md
Name: fetch_unit

Overview:
Parametrised next-generation instruction fetch stage for the pipelined RISC core. It owns the PC, drives a combinational-read instruction memory, and registers the IF/ID outputs: instruction, immediate, PC+1 and valid. Compared with the current fetch stage it adds:
- configurable widths and reset vector;
- two-word (instruction + immediate) fetch through a small state machine;
- pipeline stall;
- branch redirect with flush;
- explicit bubble insertion.

Parameters:
PC_WIDTH, 32, width of PC, imem_addr and pc_plus_one_r
INSTR_WIDTH, 16, width of one instruction memory word
RESET_VECTOR, 32, PC value loaded on reset (first instruction address, 2^5)
NOP_WORD, 0, encoding driven on instruction_r for a bubble
IMM_FLAG_BIT, 15, bit index of a fetched word; 1 = instruction is followed by an immediate word

Ports:
clk  in  1  clock, all state updates on rising edge
reset  in  1  synchronous active-high reset
stall  in  1  hold PC, state and IF/ID registers
pc_write  in  1  redirect fetch to pc_write_back_value
pc_write_back_value  in  PC_WIDTH  redirect target
clear_instruction  in  1  load a bubble into IF/ID this cycle
imem_addr  out  PC_WIDTH  instruction memory address (= PC, combinational from PC register)
imem_rdata  in  INSTR_WIDTH  word at imem_addr, same-cycle read
instruction_r  out  INSTR_WIDTH  registered instruction to decode
immediate_r  out  INSTR_WIDTH  registered immediate (valid only for two-word instructions)
pc_plus_one_r  out  PC_WIDTH  registered address following the last word of instruction_r
valid_r  out  1  1 = IF/ID holds a real instruction, 0 = bubble

Behaviour:
- Clocking and reset: single clock clk; reset is synchronous, active-high, and highest priority.
- Reset values:
  - PC = RESET_VECTOR;
  - state = S_FETCH;
  - instruction_r = NOP_WORD;
  - immediate_r = 0;
  - pc_plus_one_r = 0;
  - valid_r = 0;
  - internal hold register = NOP_WORD.
- Reset mid-two-word fetch discards the held first word.
- Update priority each edge: reset > pc_write > stall > clear_instruction > normal fetch.
- States: S_FETCH (PC points at an instruction word) and S_IMM (PC points at the immediate of a held instruction).
- S_FETCH, normal, imem_rdata[IMM_FLAG_BIT] = 0:
  - instruction_r <= imem_rdata, immediate_r <= 0, pc_plus_one_r <= PC+1, valid_r <= 1;
  - PC <= PC+1; stay in S_FETCH.
- S_FETCH, normal, imem_rdata[IMM_FLAG_BIT] = 1:
  - hold <= imem_rdata;
  - IF/ID <= bubble: instruction_r = NOP_WORD, valid_r = 0, immediate_r and pc_plus_one_r unchanged;
  - PC <= PC+1; go to S_IMM.
- S_IMM, normal:
  - instruction_r <= hold, immediate_r <= imem_rdata, pc_plus_one_r <= PC+1, valid_r <= 1;
  - PC <= PC+1; go to S_FETCH.
  - The flag bit of the immediate word is ignored.
- pc_write:
  - PC <= pc_write_back_value; state <= S_FETCH; hold discarded;
  - IF/ID <= bubble (instruction_r = NOP_WORD, valid_r = 0).
  - Overrides stall and clear_instruction in the same cycle.
- stall (no reset or pc_write): PC, state, hold and all IF/ID outputs keep their values; imem_addr is stable.
- clear_instruction (no stall):
  - IF/ID <= bubble; PC and state unchanged;
  - the word at PC is refetched next cycle.
- Arithmetic: PC+1 is modulo 2^PC_WIDTH. PC = all-ones wraps to 0, and pc_plus_one_r = 0 in that case.
- Latency: a single-word instruction appears on instruction_r one edge after its address is on imem_addr. A two-word instruction appears two edges after its first address is on imem_addr, preceded by one bubble.

Test Plan:
- Reset, then memory[32..34] = 0x0001, 0x0002, 0x0003 with single-word instructions → imem_addr is 32, 33, 34 on successive cycles; instruction_r = 0x0001, 0x0002, 0x0003 with pc_plus_one_r = 33, 34, 35 and valid_r = 1.
- memory[32] = 0x8005, memory[33] = 0x1234 → cycle 1: valid_r = 0, instruction_r = 0x0000. Cycle 2: instruction_r = 0x8005, immediate_r = 0x1234, pc_plus_one_r = 34, valid_r = 1.
- Stall held 3 cycles at PC = 40 → imem_addr stays 40; all outputs frozen. Release → fetch resumes at 40 with no skipped or duplicated instruction.
- In S_IMM, assert pc_write with target 0x0100 plus stall → next edge: PC = 0x0100, valid_r = 0, state S_FETCH. Following edge: instruction_r = memory[0x100].
- clear_instruction for one cycle at PC = 50 → instruction_r = NOP_WORD, valid_r = 0. Next edge: instruction_r = memory[50], pc_plus_one_r = 51.
- Redirect to 0xFFFFFFFF holding a single-word instruction → pc_plus_one_r = 0 and next imem_addr = 0. Assert reset mid-S_IMM → next edge: PC = 32, valid_r = 0, instruction_r = NOP_WORD.
